seq_mul_unit: RTL
=================

Name: seq_mul_unit

Overview:
- Parametrised iterative shift-add multiplier for the CPU execution datapath. Serves M/MR (signed) and unsigned multiply variants.
- Retires BITS_PER_CYCLE multiplier bits per clock and produces a 2*WIDTH-bit product.
- Uses a start/busy/ready handshake. Optionally terminates early once the remaining multiplier bits are zero.

Parameters:
- WIDTH, 32, operand width in bits; must be at least 8.
- BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle; one of 1, 2, 4; must divide WIDTH.
- EARLY_EXIT, 0, 1 = leave RUN as soon as the remaining multiplier bits are all zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new multiply; sampled on rising clk.
- signed_mode  in  1  1 = two's-complement operands; 0 = unsigned; sampled with start.
- ina  in  WIDTH  multiplicand; sampled with start.
- inb  in  WIDTH  multiplier; sampled with start.
- result  out  2*WIDTH  product; valid while ready=1.
- busy  out  1  operation in progress.
- ready  out  1  result valid; held until the next accepted start.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, result=0, busy=0, ready=0, count=0, all internal registers cleared. Reset during RUN or FIX aborts the operation; no partial result is exposed.
- States: IDLE, RUN, FIX, DONE.
- Acceptance: start is accepted only in IDLE or DONE. start while busy=1 is ignored; the current operation is unaffected.
- On the accepting edge:
  - Latch magnitudes: |ina| and |inb| when signed_mode=1 and the operand MSB=1; raw operands otherwise.
  - Latch neg = signed_mode & (ina[MSB] ^ inb[MSB]).
  - Clear the accumulator; count = WIDTH/BITS_PER_CYCLE.
  - busy=1, ready=0, state=RUN.
  - result keeps its old value until FIX.
- RUN, each cycle:
  - acc = acc + (mcand * low BITS_PER_CYCLE bits of multiplier) << shift.
  - Multiplier shifts right by BITS_PER_CYCLE; shift advances by BITS_PER_CYCLE; count decrements.
  - Leave for FIX when count reaches 0.
  - If EARLY_EXIT=1, also leave for FIX once the multiplier register, after this cycle's shift, is zero.
- FIX (one cycle): result = neg ? -acc : acc, computed modulo 2^(2*WIDTH); state=DONE.
- DONE: busy=0, ready=1. result is stable until the next accepted start, which drops ready on that same edge.
- Latency with EARLY_EXIT=0, with the accepting edge as edge 0: ready=1 after edge WIDTH/BITS_PER_CYCLE+1. Examples: 33 cycles for 32/1; 9 cycles for 32/4.
- Latency with EARLY_EXIT=1: inb=0 gives ready after edge 2.
- Arithmetic:
  - Magnitude of the most negative operand (2^(WIDTH-1)) fits in WIDTH unsigned bits, so no overflow case exists.
  - The accumulator is exactly 2*WIDTH bits; no carry-out is lost for unsigned products.
  - A zero product with neg=1 yields 0, never negative zero.
- Simultaneous events: start in DONE behaves as a fresh accept. start held high is re-accepted each time the block returns to DONE.

Decomposition:
- Shared package cpu_mul_pkg: state enumeration (IDLE/RUN/FIX/DONE) and a function for legal BITS_PER_CYCLE checks.
- One natural sub-module, mul_pp_step: combinational partial-product adder taking mcand, a BITS_PER_CYCLE-bit digit, shift and acc, and returning the new acc.
- The FSM, operand conditioning and sign fix stay in seq_mul_unit.

Test Plan:
1. Defaults, signed_mode=0, ina=3, inb=5, start one cycle -> ready=1 exactly 33 cycles after the accept edge; result=0x000000000000000F; busy low in the same cycle ready rises.
2. signed_mode=1, ina=0xFFFFFFF9 (-7), inb=6 -> result=0xFFFFFFFFFFFFFFD6. Then ina=inb=0x80000000 -> result=0x4000000000000000.
3. signed_mode=0, ina=inb=0xFFFFFFFF -> result=0xFFFFFFFE00000001. Same operands with signed_mode=1 -> result=0x0000000000000001.
4. start pulsed again at cycle 10 of a run -> ignored; original product delivered at cycle 33. Then rst_n low at cycle 12 of a new run -> busy=0, ready=0, result=0 immediately (asynchronous); no ready afterwards until a new start.
5. BITS_PER_CYCLE=4: ina=0x12345678, inb=0x9ABCDEF0, unsigned -> result=0x0B00EA4E242D2080, ready after 9 cycles.
6. EARLY_EXIT=1: inb=0 -> ready after 2 cycles, result=0; inb=1, ina=0xFFFFFFFF signed -> result=0xFFFFFFFFFFFFFFFF, ready after 2 cycles.

Source files
------------

// File: rtl/cpu_mul_pkg.sv
// rtl/cpu_mul_pkg.sv - shared state encoding and parameter checks for the sequential multiplier
package cpu_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_t;

    // Digit width must be 1, 2 or 4 and tile the operand exactly.
    function automatic bit bpc_legal(input int bpc, input int width);
        if (width < 8)
            return 1'b0;
        if (bpc != 1 && bpc != 2 && bpc != 4)
            return 1'b0;
        return (width % bpc) == 0;
    endfunction

endpackage

// File: rtl/seq_mul_unit_if.sv
// rtl/seq_mul_unit_if.sv - start/busy/ready operand and result bundle for seq_mul_unit
interface seq_mul_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     ina;
    logic [WIDTH-1:0]     inb;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;
    logic                 ready;

    modport master (
        output start, signed_mode, ina, inb,
        input  result, busy, ready
    );

    modport slave (
        input  start, signed_mode, ina, inb,
        output result, busy, ready
    );
endinterface

// File: rtl/mul_pp_step.sv
// rtl/mul_pp_step.sv - one shift-add step: acc + (mcand * digit) << shift
module mul_pp_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SHIFT_W        = 6
) (
    input  logic [WIDTH-1:0]          mcand,
    input  logic [BITS_PER_CYCLE-1:0] digit,
    input  logic [SHIFT_W-1:0]        shift,
    input  logic [2*WIDTH-1:0]        acc_in,
    output logic [2*WIDTH-1:0]        acc_out
);
    logic [2*WIDTH-1:0] mcand_ext;
    logic [2*WIDTH-1:0] digit_ext;
    logic [2*WIDTH-1:0] pp;

    assign mcand_ext = {{WIDTH{1'b0}}, mcand};
    assign digit_ext = {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, digit};
    // The product of a WIDTH-bit value and a small digit never exceeds 2*WIDTH bits.
    assign pp        = mcand_ext * digit_ext;
    assign acc_out   = acc_in + (pp << shift);
endmodule

// File: rtl/seq_mul_unit.sv
// rtl/seq_mul_unit.sv - iterative signed/unsigned shift-add multiplier with optional early exit
module seq_mul_unit
    import cpu_mul_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter bit EARLY_EXIT     = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_mul_unit_if.slave  bus
);
    localparam int STEPS   = WIDTH / BITS_PER_CYCLE;
    localparam int COUNT_W = $clog2(STEPS + 1);
    localparam int SHIFT_W = $clog2(WIDTH) + 1;

    if (!bpc_legal(BITS_PER_CYCLE, WIDTH)) begin : g_bad_param
        $error("seq_mul_unit: illegal WIDTH/BITS_PER_CYCLE combination");
    end

    mul_state_t             state, state_nxt;
    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       mplier;
    logic [WIDTH-1:0]       mplier_shifted;
    logic [2*WIDTH-1:0]     acc;
    logic [2*WIDTH-1:0]     acc_nxt;
    logic [2*WIDTH-1:0]     result_q;
    logic [SHIFT_W-1:0]     shift;
    logic [COUNT_W-1:0]     count;
    logic                   neg;
    logic                   accept;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;

    // Negating the most negative value yields 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign mag_a = (bus.signed_mode && bus.ina[WIDTH-1]) ? -bus.ina : bus.ina;
    assign mag_b = (bus.signed_mode && bus.inb[WIDTH-1]) ? -bus.inb : bus.inb;

    assign mplier_shifted = mplier >> BITS_PER_CYCLE;

    mul_pp_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .SHIFT_W        (SHIFT_W)
    ) u_pp_step (
        .mcand   (mcand),
        .digit   (mplier[BITS_PER_CYCLE-1:0]),
        .shift   (shift),
        .acc_in  (acc),
        .acc_out (acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (count == COUNT_W'(1) || (EARLY_EXIT && mplier_shifted == '0))
                    state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            shift    <= '0;
            count    <= '0;
            neg      <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= bus.signed_mode & (bus.ina[WIDTH-1] ^ bus.inb[WIDTH-1]);
            acc    <= '0;
            shift  <= '0;
            count  <= COUNT_W'(STEPS);
        end else if (state == ST_RUN) begin
            acc    <= acc_nxt;
            mplier <= mplier_shifted;
            shift  <= shift + SHIFT_W'(BITS_PER_CYCLE);
            count  <= count - COUNT_W'(1);
        end else if (state == ST_FIX) begin
            // Two's-complement negation of zero is zero, so no negative-zero case arises.
            result_q <= neg ? -acc : acc;
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = (state == ST_RUN) || (state == ST_FIX);
    assign bus.ready  = (state == ST_DONE);
endmodule
